fetch_stage: RTL

Instruction-fetch stage of the pipelined MIPS core. It owns the program counter, drives the address into the asynchronous-read program memory, and captures the returned instruction into the IF/ID pipeline register. It handles hazard stalls, branch/jump redirects, flushes, and halting on illegal or out-of-range fetch addresses.

---
 rtl/mips_fetch_pkg.sv | 29 ++
 rtl/ifid_register.sv | 45 ++++
 rtl/fetch_stage.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mips_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: state encodings,
// IF/ID control codes, the NOP word and the fetch-window check.
package mips_fetch_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  typedef enum logic [1:0] {
    IFID_HOLD   = 2'd0,
    IFID_LOAD   = 2'd1,
    IFID_BUBBLE = 2'd2
  } ifid_ctrl_t;

  localparam logic [31:0] NOP              = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // True when addr is word aligned and base <= addr < base + 4*depth.
  // Arguments are widened to 64 bits so the upper limit cannot wrap.
  function automatic logic in_window(input logic [63:0] addr,
                                     input logic [63:0] base,
                                     input logic [63:0] depth);
    logic [63:0] limit;
    limit = base + (depth << 2);
    return (addr[1:0] == 2'b00) && (addr >= base) && (addr < limit);
  endfunction

endpackage

// File: rtl/ifid_register.sv
// IF/ID pipeline register: instruction, PC+4 and valid flag with
// load / hold / bubble control.
module ifid_register
  import mips_fetch_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  ifid_ctrl_t            ctrl,
  input  logic [DATA_WIDTH-1:0] instr_in,
  input  logic [DATA_WIDTH-1:0] pc_plus4_in,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic [DATA_WIDTH-1:0] pc_plus4,
  output logic                  valid
);

  // Capture a new instruction, keep the current one, or insert a NOP bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instruction <= DATA_WIDTH'(NOP);
      pc_plus4    <= '0;
      valid       <= 1'b0;
    end else begin
      case (ctrl)
        IFID_LOAD: begin
          instruction <= instr_in;
          pc_plus4    <= pc_plus4_in;
          valid       <= 1'b1;
        end
        IFID_BUBBLE: begin
          instruction <= DATA_WIDTH'(NOP);
          pc_plus4    <= '0;
          valid       <= 1'b0;
        end
        default: begin
          instruction <= instruction;
          pc_plus4    <= pc_plus4;
          valid       <= valid;
        end
      endcase
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, next-PC selection, RUN/HALT
// control, fetch counter and the IF/ID register instance.
//
//   state | meaning
//   RUN   | fetching; PC advances, redirects or holds on Stall
//   HALT  | fetch stopped after a bad target or run-off; left only by reset
module fetch_stage
  import mips_fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MEMORY_DEPTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC     = DATA_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Stall,
  input  logic                  Flush,
  input  logic                  Jump,
  input  logic [DATA_WIDTH-1:0] JumpTarget,
  input  logic                  BranchTaken,
  input  logic [DATA_WIDTH-1:0] BranchTarget,
  input  logic [DATA_WIDTH-1:0] Instruction_i,
  output logic [DATA_WIDTH-1:0] PC_o,
  output logic [DATA_WIDTH-1:0] IFID_Instruction,
  output logic [DATA_WIDTH-1:0] IFID_PCPlus4,
  output logic                  IFID_Valid,
  output logic                  Halted,
  output logic                  AddrError,
  output logic [31:0]           FetchCount
);

  fetch_state_t          state;
  fetch_state_t          state_next;
  logic [DATA_WIDTH-1:0] pc_next;
  logic [DATA_WIDTH-1:0] pc_plus4;
  logic [DATA_WIDTH-1:0] target;
  logic                  redirect;
  logic                  target_ok;
  logic                  seq_ok;
  logic                  set_addr_error;
  ifid_ctrl_t            ifid_ctrl;

  assign pc_plus4  = PC_o + DATA_WIDTH'(4);
  assign redirect  = Jump | BranchTaken;
  assign target    = Jump ? JumpTarget : BranchTarget;
  assign target_ok = in_window(64'(target), 64'(RESET_PC), 64'(MEMORY_DEPTH));
  assign seq_ok    = in_window(64'(pc_plus4), 64'(RESET_PC), 64'(MEMORY_DEPTH));
  assign Halted    = (state == HALT);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  // Next state: halt on an illegal redirect target or on sequential run-off.
  always_comb begin
    state_next = state;
    case (state)
      RUN: begin
        if (redirect && !target_ok)
          state_next = HALT;
        else if (!redirect && !Stall && !seq_ok)
          state_next = HALT;
      end
      default: state_next = HALT;
    endcase
  end

  // Per-state control: next PC, IF/ID action and error flag set.
  always_comb begin
    pc_next        = PC_o;
    ifid_ctrl      = IFID_BUBBLE;
    set_addr_error = 1'b0;
    case (state)
      RUN: begin
        if (redirect) begin
          if (target_ok) begin
            pc_next = target;
            if (Flush)      ifid_ctrl = IFID_BUBBLE;
            else if (Stall) ifid_ctrl = IFID_HOLD;
            else            ifid_ctrl = IFID_LOAD;
          end else begin
            set_addr_error = 1'b1;
          end
        end else if (Stall) begin
          ifid_ctrl = Flush ? IFID_BUBBLE : IFID_HOLD;
        end else begin
          // On run-off the PC holds but the last in-window word still loads.
          if (seq_ok) pc_next = pc_plus4;
          ifid_ctrl = Flush ? IFID_BUBBLE : IFID_LOAD;
        end
      end
      default: begin
        pc_next   = PC_o;
        ifid_ctrl = IFID_BUBBLE;
      end
    endcase
  end

  // Program counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) PC_o <= RESET_PC;
    else       PC_o <= pc_next;
  end

  // Sticky bad-target flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               AddrError <= 1'b0;
    else if (set_addr_error) AddrError <= 1'b1;
  end

  // Count valid instructions entering IF/ID.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        FetchCount <= 32'd0;
    else if (ifid_ctrl == IFID_LOAD)  FetchCount <= FetchCount + 32'd1;
  end

  ifid_register #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ifid (
    .clk         (clk),
    .reset       (reset),
    .ctrl        (ifid_ctrl),
    .instr_in    (Instruction_i),
    .pc_plus4_in (pc_plus4),
    .instruction (IFID_Instruction),
    .pc_plus4    (IFID_PCPlus4),
    .valid       (IFID_Valid)
  );

endmodule
